btn_debounce_ctrl: RTL and testbench

Debounce and event scheduler for the Basys3 push buttons. It generates the shared slow sampling tick from the 100 MHz board clock and runs one debounce state machine per button off that tick. It outputs a clean level plus single-cycle press, release and long-hold pulses to the display/sound control logic. It replaces the ad-hoc slow-clock flip-flop chains, so the whole design runs in one clock domain and uses the tick only as an enable.

---
 rtl/btn_debounce_ctrl_if.sv | 21 ++
 rtl/btn_debounce_ctrl.sv | 168 ++++++++++++++++
 tb/tb_btn_debounce_ctrl.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/btn_debounce_ctrl_if.sv
// Button bus: raw pins in, debounced level and event pulses out.
interface btn_debounce_ctrl_if #(
   parameter int unsigned NUM_BTN = 5
);
   logic [NUM_BTN-1:0] push_button;
   logic               sample_tick;
   logic [NUM_BTN-1:0] btn_level;
   logic [NUM_BTN-1:0] btn_press;
   logic [NUM_BTN-1:0] btn_release;
   logic [NUM_BTN-1:0] btn_hold;

   modport master (
      output push_button,
      input  sample_tick, btn_level, btn_press, btn_release, btn_hold
   );

   modport slave (
      input  push_button,
      output sample_tick, btn_level, btn_press, btn_release, btn_hold
   );
endinterface

// File: rtl/btn_debounce_ctrl.sv
// Push-button debouncer: shared sample tick, 2-FF synchronizers and one
// debounce FSM per button producing level, press, release and hold events.
module btn_debounce_ctrl #(
   parameter int unsigned NUM_BTN      = 5,
   parameter int unsigned TICK_DIV     = 250000,
   parameter int unsigned STABLE_TICKS = 4,
   parameter int unsigned HOLD_TICKS   = 400
) (
   input  logic          clock,
   input  logic          reset,
   btn_debounce_ctrl_if.slave bus
);

   localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned CW = $clog2(STABLE_TICKS + 1);
   localparam int unsigned HW = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;

   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
   localparam logic [CW-1:0] CNT_LAST  = CW'(STABLE_TICKS - 1);
   localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_TICKS);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);

   typedef enum logic [1:0] {
      IDLE,
      PRESS_CHK,
      PRESSED,
      RELEASE_CHK
   } state_t;

   logic [TW-1:0]      tick_cnt;
   logic               tick;
   logic [NUM_BTN-1:0] sync_a;
   logic [NUM_BTN-1:0] sync;

   state_t             state_q [NUM_BTN];
   state_t             state_d [NUM_BTN];
   logic [CW-1:0]      cnt_q   [NUM_BTN];
   logic [CW-1:0]      cnt_d   [NUM_BTN];
   logic [HW-1:0]      hcnt_q  [NUM_BTN];
   logic [HW-1:0]      hcnt_d  [NUM_BTN];

   logic [NUM_BTN-1:0] level_q, level_d;
   logic [NUM_BTN-1:0] press_q, press_d;
   logic [NUM_BTN-1:0] rel_q,   rel_d;
   logic [NUM_BTN-1:0] hold_q,  hold_d;

   // Sample-tick divider: registered tick follows the terminal count by one cycle.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         tick_cnt <= '0;
         tick     <= 1'b0;
      end else if (tick_cnt == TICK_LAST) begin
         tick_cnt <= '0;
         tick     <= 1'b1;
      end else begin
         tick_cnt <= tick_cnt + TW'(1);
         tick     <= 1'b0;
      end
   end

   // Two-stage synchronizer for the raw button pins.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync_a <= '0;
         sync   <= '0;
      end else begin
         sync_a <= bus.push_button;
         sync   <= sync_a;
      end
   end

   // FSM state, counters and registered outputs for every button.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < NUM_BTN; i++) begin
            state_q[i] <= IDLE;
            cnt_q[i]   <= '0;
            hcnt_q[i]  <= '0;
         end
         level_q <= '0;
         press_q <= '0;
         rel_q   <= '0;
         hold_q  <= '0;
      end else begin
         for (int unsigned i = 0; i < NUM_BTN; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
            hcnt_q[i]  <= hcnt_d[i];
         end
         level_q <= level_d;
         press_q <= press_d;
         rel_q   <= rel_d;
         hold_q  <= hold_d;
      end
   end

   // Next-state and event logic; transitions only on tick cycles, pulses default low.
   always_comb begin
      level_d = level_q;
      press_d = '0;
      rel_d   = '0;
      hold_d  = '0;
      for (int unsigned i = 0; i < NUM_BTN; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
         hcnt_d[i]  = hcnt_q[i];
         if (tick) begin
            case (state_q[i])
               IDLE: begin
                  if (sync[i]) begin
                     state_d[i] = PRESS_CHK;
                     cnt_d[i]   = CW'(1);
                  end
               end
               PRESS_CHK: begin
                  if (!sync[i]) begin
                     state_d[i] = IDLE;
                     cnt_d[i]   = '0;
                  end else if (cnt_q[i] == CNT_LAST) begin
                     state_d[i] = PRESSED;
                     cnt_d[i]   = '0;
                     hcnt_d[i]  = '0;
                     level_d[i] = 1'b1;
                     press_d[i] = 1'b1;
                  end else begin
                     cnt_d[i] = cnt_q[i] + CW'(1);
                  end
               end
               PRESSED: begin
                  if (!sync[i]) begin
                     state_d[i] = RELEASE_CHK;
                     cnt_d[i]   = CW'(1);
                  end else if (hcnt_q[i] != HOLD_MAX) begin
                     hcnt_d[i] = hcnt_q[i] + HW'(1);
                     if (hcnt_q[i] == HOLD_LAST) begin
                        hold_d[i] = 1'b1;
                     end
                  end
               end
               RELEASE_CHK: begin
                  if (sync[i]) begin
                     state_d[i] = PRESSED;
                     cnt_d[i]   = '0;
                  end else if (cnt_q[i] == CNT_LAST) begin
                     state_d[i] = IDLE;
                     cnt_d[i]   = '0;
                     level_d[i] = 1'b0;
                     rel_d[i]   = 1'b1;
                  end else begin
                     cnt_d[i] = cnt_q[i] + CW'(1);
                  end
               end
               default: begin
                  state_d[i] = IDLE;
                  cnt_d[i]   = '0;
               end
            endcase
         end
      end
   end

   assign bus.sample_tick = tick;
   assign bus.btn_level   = level_q;
   assign bus.btn_press   = press_q;
   assign bus.btn_release = rel_q;
   assign bus.btn_hold    = hold_q;

endmodule

// File: tb/tb_btn_debounce_ctrl.sv
// Bench for btn_debounce_ctrl: directed scenarios plus random button activity,
// checked every cycle against a run-length reference model.
module tb_btn_debounce_ctrl;

   localparam int N  = 5;
   localparam int TD = 4;
   localparam int ST = 3;
   localparam int HT = 5;

   logic         clock;
   logic         reset;
   logic [N-1:0] push;

   btn_debounce_ctrl_if #(.NUM_BTN(N)) bus ();

   assign bus.push_button = push;

   btn_debounce_ctrl #(
      .NUM_BTN(N),
      .TICK_DIV(TD),
      .STABLE_TICKS(ST),
      .HOLD_TICKS(HT)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus(bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_cmp = 0;
   int n_bad = 0;

   // reference model: debounced level flips after ST consecutive disagreeing tick samples
   int           m_edges;
   logic         m_tick;
   logic [N-1:0] m_s1, m_s2, m_lvl, m_press, m_rel, m_hold;
   int           m_run  [N];
   int           m_held [N];

   // observed event statistics per scenario
   int cnt_press [N];
   int cnt_rel   [N];
   int cnt_hold  [N];
   int first_press [N];
   int first_hold  [N];
   int n_ticks;
   int first_tick;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_edges = 0;
      m_tick  = 1'b0;
      m_s1    = '0;
      m_s2    = '0;
      m_lvl   = '0;
      m_press = '0;
      m_rel   = '0;
      m_hold  = '0;
      for (int i = 0; i < N; i++) begin
         m_run[i]  = 0;
         m_held[i] = 0;
      end
   endtask

   task automatic model_edge(input logic [N-1:0] pb);
      logic [N-1:0] smp;
      logic         tk;
      smp = m_s2;
      tk  = m_tick;
      m_press = '0;
      m_rel   = '0;
      m_hold  = '0;
      if (tk) begin
         for (int i = 0; i < N; i++) begin
            if (smp[i] != m_lvl[i]) begin
               m_run[i]++;
               if (m_run[i] == ST) begin
                  m_lvl[i] = smp[i];
                  m_run[i] = 0;
                  if (smp[i]) begin
                     m_press[i] = 1'b1;
                     m_held[i]  = 0;
                  end else begin
                     m_rel[i] = 1'b1;
                  end
               end
            end else begin
               // held ticks only count while not in the middle of a release check
               if (m_lvl[i] && m_run[i] == 0 && m_held[i] < HT) begin
                  m_held[i]++;
                  if (m_held[i] == HT) m_hold[i] = 1'b1;
               end
               m_run[i] = 0;
            end
         end
      end
      m_s2 = m_s1;
      m_s1 = pb;
      m_edges++;
      m_tick = ((m_edges % TD) == 0);
   endtask

   task automatic compare_all();
      check("tick",    32'(bus.sample_tick), 32'(m_tick));
      check("level",   32'(bus.btn_level),   32'(m_lvl));
      check("press",   32'(bus.btn_press),   32'(m_press));
      check("release", 32'(bus.btn_release), 32'(m_rel));
      check("hold",    32'(bus.btn_hold),    32'(m_hold));
      check("excl", 32'((bus.btn_press & bus.btn_release) |
                         (bus.btn_hold & (bus.btn_press | bus.btn_release))), 32'(0));
   endtask

   task automatic clear_stats();
      for (int i = 0; i < N; i++) begin
         cnt_press[i]   = 0;
         cnt_rel[i]     = 0;
         cnt_hold[i]    = 0;
         first_press[i] = -1;
         first_hold[i]  = -1;
      end
      n_ticks    = 0;
      first_tick = -1;
   endtask

   task automatic step();
      logic [N-1:0] pb;
      pb = push;
      @(posedge clock);
      if (reset) model_reset();
      else       model_edge(pb);
      #1;
      compare_all();
      if (bus.sample_tick) begin
         if (n_ticks == 0) first_tick = m_edges;
         n_ticks++;
      end
      for (int i = 0; i < N; i++) begin
         if (bus.btn_press[i]) begin
            if (first_press[i] < 0) first_press[i] = m_edges;
            cnt_press[i]++;
         end
         if (bus.btn_release[i]) cnt_rel[i]++;
         if (bus.btn_hold[i]) begin
            if (first_hold[i] < 0) first_hold[i] = m_edges;
            cnt_hold[i]++;
         end
      end
   endtask

   task automatic steps(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   // called 1 unit after a rising edge: deassert between edges and apply new pins
   task automatic release_reset(input logic [N-1:0] pb);
      #3;
      reset = 1'b0;
      push  = pb;
   endtask

   // asynchronous reset mid-cycle; outputs must clear without waiting for a clock edge
   task automatic do_reset(input logic [N-1:0] pb_after);
      #2;
      reset = 1'b1;
      model_reset();
      #1;
      compare_all();
      steps(2);
      release_reset(pb_after);
   endtask

   int sum_pulses;

   initial begin
      reset = 1'b1;
      push  = '0;
      model_reset();
      clear_stats();

      // reset and tick cadence
      steps(2);
      release_reset('0);
      clear_stats();
      steps(20);
      check("first_tick", 32'(first_tick), 32'(4));
      check("tick_count", 32'(n_ticks), 32'(5));
      sum_pulses = 0;
      for (int i = 0; i < N; i++) sum_pulses += cnt_press[i] + cnt_rel[i] + cnt_hold[i];
      check("idle_pulses", 32'(sum_pulses), 32'(0));

      // clean press on button 0 from reset release
      do_reset(5'b00001);
      clear_stats();
      steps(20);
      check("b0_press_edge", 32'(first_press[0]), 32'(13));
      check("b0_press_cnt",  32'(cnt_press[0]),   32'(1));
      check("b0_level",      32'(bus.btn_level),  32'(5'b00001));
      push = '0;
      steps(30);

      // glitch rejection on button 2
      clear_stats();
      push[2] = 1'b1;
      steps(5);
      push[2] = 1'b0;
      steps(10);
      for (int c = 0; c < 100; c++) begin
         push[2] = ((c % 6) < 3);
         step();
      end
      push = '0;
      steps(20);
      sum_pulses = 0;
      for (int i = 0; i < N; i++) sum_pulses += cnt_press[i] + cnt_rel[i] + cnt_hold[i];
      check("glitch_pulses", 32'(sum_pulses), 32'(0));
      check("glitch_level",  32'(bus.btn_level[2]), 32'(0));

      // hold and release on button 1
      clear_stats();
      push[1] = 1'b1;
      steps(40);
      push[1] = 1'b0;
      steps(30);
      check("b1_press_cnt", 32'(cnt_press[1]), 32'(1));
      check("b1_hold_cnt",  32'(cnt_hold[1]),  32'(1));
      check("b1_hold_gap",  32'(first_hold[1] - first_press[1]), 32'(HT * TD));
      check("b1_rel_cnt",   32'(cnt_rel[1]),   32'(1));
      check("b1_level",     32'(bus.btn_level[1]), 32'(0));

      // release bounce on button 3: one low tick must not release
      clear_stats();
      push[3] = 1'b1;
      steps(20);
      push[3] = 1'b0;
      steps(TD);
      push[3] = 1'b1;
      steps(20);
      check("b3_press_cnt", 32'(cnt_press[3]), 32'(1));
      check("b3_rel_cnt",   32'(cnt_rel[3]),   32'(0));
      check("b3_level",     32'(bus.btn_level[3]), 32'(1));
      push = '0;
      steps(30);

      // simultaneous buttons 0 and 4, then reset while held
      clear_stats();
      push = 5'b10001;
      steps(25);
      check("b04_press_cnt", 32'(cnt_press[0] + cnt_press[4]), 32'(2));
      check("b04_same_edge", 32'(first_press[0] - first_press[4]), 32'(0));
      do_reset(5'b10001);
      check("rst_level", 32'(bus.btn_level), 32'(0));
      clear_stats();
      steps(20);
      check("b0_repress_edge", 32'(first_press[0]), 32'(13));
      check("b4_repress_edge", 32'(first_press[4]), 32'(13));
      check("b04_level", 32'(bus.btn_level), 32'(5'b10001));
      push = '0;
      steps(30);

      // random button activity with occasional asynchronous reset
      for (int seg = 0; seg < 80; seg++) begin
         if ($urandom_range(0, 19) == 0) begin
            do_reset(N'($urandom));
         end else begin
            for (int i = 0; i < N; i++)
               if ($urandom_range(0, 2) == 0) push[i] = ~push[i];
         end
         steps(int'($urandom_range(1, 30)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
